// File: rtl/hdlc_ctrl_pkg.sv
// Shared types and sizing helpers for the HDLC transmit scheduler.
`timescale 1ns/1ps
package hdlc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANTED,
        WAIT_VALID,
        SENDING,
        ABORTING,
        GAP
    } state_t;

    localparam int GAP_CYCLES_DEF    = 9;
    localparam int START_TIMEOUT_DEF = 64;

    // One counter serves both the start timeout and the post-frame gap.
    function automatic int cnt_width(input int gap, input int timeout);
        int biggest;
        biggest = (gap > timeout) ? gap : timeout;
        return $clog2(biggest + 1);
    endfunction

endpackage

// File: rtl/hdlc_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
`timescale 1ns/1ps
module hdlc_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [PW-1:0]    idx,
    output logic             any
);

    always_comb begin : pick
        int j;
        j      = 0;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(ptr) + i) % N_REQ;
            if (!any && req[j]) begin
                any       = 1'b1;
                onehot[j] = 1'b1;
                idx       = PW'(j);
            end
        end
    end

endmodule

// File: rtl/hdlc_tx_scheduler.sv
// Round-robin owner of the shared HDLC transmitter: grants a client, sequences
// start/abort of its frame, reports the outcome and enforces an idle gap.
`timescale 1ns/1ps
module hdlc_tx_scheduler
    import hdlc_ctrl_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int GAP_CYCLES    = GAP_CYCLES_DEF,
    parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [N_REQ-1:0] Req,
    input  logic [N_REQ-1:0] Start,
    input  logic [N_REQ-1:0] Abort,
    output logic [N_REQ-1:0] Grant,
    output logic [N_REQ-1:0] Done,
    output logic [N_REQ-1:0] Aborted,
    output logic [N_REQ-1:0] Timeout,
    output logic             Busy,
    output logic             Tx_Enable,
    output logic             Tx_AbortFrame,
    input  logic             Tx_ValidFrame,
    input  logic             Tx_AbortedTrans
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = cnt_width(GAP_CYCLES, START_TIMEOUT);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gidx;
    logic            abt_seen;

    logic [N_REQ-1:0] win_onehot;
    logic [PW-1:0]    win_idx;
    logic             win_any;

    logic start_g;
    logic abort_g;
    logic req_g;

    hdlc_rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_arb (
        .req    (Req),
        .ptr    (ptr),
        .onehot (win_onehot),
        .idx    (win_idx),
        .any    (win_any)
    );

    // Only the granted client's controls are ever looked at.
    assign start_g = Start[gidx];
    assign abort_g = Abort[gidx];
    assign req_g   = Req[gidx];
    assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state         <= IDLE;
            cnt           <= '0;
            ptr           <= '0;
            gidx          <= '0;
            abt_seen      <= 1'b0;
            Grant         <= '0;
            Done          <= '0;
            Aborted       <= '0;
            Timeout       <= '0;
            Busy          <= 1'b0;
            Tx_Enable     <= 1'b0;
            Tx_AbortFrame <= 1'b0;
        end else begin
            Tx_Enable     <= 1'b0;
            Tx_AbortFrame <= 1'b0;
            Done          <= '0;
            Aborted       <= '0;
            Timeout       <= '0;

            case (state)
                IDLE: begin
                    if (win_any) begin
                        Grant <= win_onehot;
                        gidx  <= win_idx;
                        ptr   <= (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                        Busy  <= 1'b1;
                        state <= GRANTED;
                    end
                end

                GRANTED: begin
                    if (start_g) begin
                        Tx_Enable <= 1'b1;
                        cnt       <= '0;
                        state     <= WAIT_VALID;
                    end else if (!req_g) begin
                        Grant <= '0;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                // Abort outranks a simultaneous frame start.
                WAIT_VALID: begin
                    if (abort_g) begin
                        Tx_AbortFrame <= 1'b1;
                        abt_seen      <= 1'b0;
                        state         <= ABORTING;
                    end else if (Tx_ValidFrame) begin
                        state <= SENDING;
                    end else if (cnt == CW'(START_TIMEOUT - 1)) begin
                        Timeout <= Grant;
                        Grant   <= '0;
                        cnt     <= '0;
                        state   <= GAP;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                // A frame that ends on its own outranks a late abort.
                SENDING: begin
                    if (!Tx_ValidFrame) begin
                        Done  <= Grant;
                        Grant <= '0;
                        cnt   <= '0;
                        state <= GAP;
                    end else if (abort_g) begin
                        Tx_AbortFrame <= 1'b1;
                        abt_seen      <= 1'b0;
                        state         <= ABORTING;
                    end
                end

                ABORTING: begin
                    if (!Tx_ValidFrame) begin
                        if (abt_seen || Tx_AbortedTrans) begin
                            Aborted <= Grant;
                        end else begin
                            Done <= Grant;
                        end
                        Grant <= '0;
                        cnt   <= '0;
                        state <= GAP;
                    end else begin
                        abt_seen <= abt_seen | Tx_AbortedTrans;
                    end
                end

                GAP: begin
                    if (cnt == CW'(GAP_CYCLES - 1)) begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                default: begin
                    Grant <= '0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdlc_tx_scheduler.sv
// Scoreboard bench for hdlc_tx_scheduler: stimulus queues expected output events, a monitor compares them.
`timescale 1ns/1ps
module tb_hdlc_tx_scheduler;

    typedef struct packed {
        logic [3:0] grant;
        logic       busy;
        logic       en;
        logic       ab;
        logic [3:0] done;
        logic [3:0] abt;
        logic [3:0] to;
    } snap_t;

    typedef struct {
        snap_t s;
        int    cyc;
        string name;
    } exp_t;

    logic       Clk;
    logic       Rst;
    logic [3:0] Req;
    logic [3:0] Start;
    logic [3:0] Abort;
    logic [3:0] Grant;
    logic [3:0] Done;
    logic [3:0] Aborted;
    logic [3:0] Timeout;
    logic       Busy;
    logic       Tx_Enable;
    logic       Tx_AbortFrame;
    logic       Tx_ValidFrame;
    logic       Tx_AbortedTrans;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    logic  mon_en = 1'b0;
    exp_t  q[$];
    snap_t mon_s;
    exp_t  mon_e;
    logic [3:0] prev_g = '0;
    logic       prev_b = 1'b0;

    hdlc_tx_scheduler #(
        .N_REQ         (4),
        .GAP_CYCLES    (9),
        .START_TIMEOUT (64)
    ) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Req             (Req),
        .Start           (Start),
        .Abort           (Abort),
        .Grant           (Grant),
        .Done            (Done),
        .Aborted         (Aborted),
        .Timeout         (Timeout),
        .Busy            (Busy),
        .Tx_Enable       (Tx_Enable),
        .Tx_AbortFrame   (Tx_AbortFrame),
        .Tx_ValidFrame   (Tx_ValidFrame),
        .Tx_AbortedTrans (Tx_AbortedTrans)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic snap_t mk(input logic [3:0] g, input logic b, input logic en,
                                 input logic ab, input logic [3:0] d, input logic [3:0] a,
                                 input logic [3:0] t);
        snap_t s;
        s.grant = g; s.busy = b; s.en = en; s.ab = ab;
        s.done = d; s.abt = a; s.to = t;
        return s;
    endfunction

    function automatic snap_t cur();
        return mk(Grant, Busy, Tx_Enable, Tx_AbortFrame, Done, Aborted, Timeout);
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("grant=%b busy=%b tx_en=%b tx_abort=%b done=%b aborted=%b timeout=%b",
                         s.grant, s.busy, s.en, s.ab, s.done, s.abt, s.to);
    endfunction

    task automatic exp_ev(input string nm, input int c, input snap_t s);
        exp_t e;
        e.s = s; e.cyc = c; e.name = nm;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Monitor: any pulse or any change of Grant/Busy is an event to be matched.
    always @(negedge Clk) begin
        if (mon_en) begin
            mon_s = cur();
            while (q.size() > 0 && q[0].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: nothing seen at cycle %0d, required %s",
                         q[0].name, q[0].cyc, fmt(q[0].s));
                void'(q.pop_front());
            end
            if (mon_s.en || mon_s.ab || mon_s.done != 0 || mon_s.abt != 0 || mon_s.to != 0 ||
                mon_s.grant != prev_g || mon_s.busy != prev_b) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: cycle %0d got %s, required no event",
                             cyc, fmt(mon_s));
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.cyc != cyc || mon_e.s != mon_s) begin
                        n_fail++;
                        $display("FAIL %s: cycle %0d got %s, required cycle %0d %s",
                                 mon_e.name, cyc, fmt(mon_s), mon_e.cyc, fmt(mon_e.s));
                    end
                end
            end
            prev_g = mon_s.grant;
            prev_b = mon_s.busy;
        end
    end

    // Precondition: arbitration will grant client cl on the next edge.
    task automatic frame(input int cl, input int nvalid, input logic [3:0] req_after);
        int c;
        logic [3:0] g;
        c = cyc;
        g = 4'b0001 << cl;
        exp_ev("grant", c + 1, mk(g, 1, 0, 0, 0, 0, 0));
        tick();
        Start = g;
        exp_ev("tx_enable", c + 2, mk(g, 1, 1, 0, 0, 0, 0));
        tick();
        Start = '0;
        Tx_ValidFrame = 1'b1;
        repeat (nvalid) tick();
        Tx_ValidFrame = 1'b0;
        Req = req_after;
        exp_ev("done", cyc + 1, mk(4'b0000, 1, 0, 0, g, 0, 0));
        exp_ev("gap_end", cyc + 10, mk(4'b0000, 0, 0, 0, 0, 0, 0));
        repeat (10) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        Rst = 1'b0;
        Req = '0; Start = '0; Abort = '0;
        Tx_ValidFrame = 1'b0;
        Tx_AbortedTrans = 1'b0;
        repeat (3) tick();
        Rst = 1'b1;
        tick();
        n_checks++;
        if (cur() != mk(0, 0, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_state: got %s, required all zero", fmt(cur()));
        end
        mon_en = 1'b1;

        // Single frame from client 1.
        Req = 4'b0010;
        frame(1, 20, 4'b0000);

        // Fresh pointer, all clients requesting: strict rotation with gaps.
        Rst = 1'b0;
        repeat (2) tick();
        Rst = 1'b1;
        Req = 4'b1111;
        frame(0, 5, 4'b1111);
        frame(1, 5, 4'b1111);
        frame(2, 5, 4'b1111);
        frame(3, 5, 4'b0000);

        // Client 2 aborts mid-frame; second abort pulse must be ignored.
        c = cyc;
        Req = 4'b0100;
        exp_ev("grant", c + 1, mk(4'b0100, 1, 0, 0, 0, 0, 0));
        tick();
        Start = 4'b0100;
        exp_ev("tx_enable", c + 2, mk(4'b0100, 1, 1, 0, 0, 0, 0));
        tick();
        Start = '0;
        Tx_ValidFrame = 1'b1;
        repeat (3) tick();
        Abort = 4'b0100;
        exp_ev("tx_abort", c + 6, mk(4'b0100, 1, 0, 1, 0, 0, 0));
        tick();
        Abort = '0;
        Tx_AbortedTrans = 1'b1;
        tick();
        Tx_AbortedTrans = 1'b0;
        Abort = 4'b0100;
        tick();
        Abort = '0;
        tick();
        Tx_ValidFrame = 1'b0;
        Req = '0;
        exp_ev("aborted", c + 10, mk(4'b0000, 1, 0, 0, 0, 4'b0100, 0));
        exp_ev("gap_end", c + 19, mk(0, 0, 0, 0, 0, 0, 0));
        repeat (11) tick();

        // Client 3 starts but the transmitter never raises Tx_ValidFrame.
        c = cyc;
        Req = 4'b1000;
        exp_ev("grant", c + 1, mk(4'b1000, 1, 0, 0, 0, 0, 0));
        tick();
        Start = 4'b1000;
        exp_ev("tx_enable", c + 2, mk(4'b1000, 1, 1, 0, 0, 0, 0));
        tick();
        Start = '0;
        Req = '0;
        exp_ev("timeout", c + 66, mk(4'b0000, 1, 0, 0, 0, 0, 4'b1000));
        exp_ev("gap_end", c + 75, mk(0, 0, 0, 0, 0, 0, 0));
        repeat (74) tick();

        // Abort coincides with the end of frame: completion wins.
        c = cyc;
        Req = 4'b0001;
        exp_ev("grant", c + 1, mk(4'b0001, 1, 0, 0, 0, 0, 0));
        tick();
        Start = 4'b0001;
        exp_ev("tx_enable", c + 2, mk(4'b0001, 1, 1, 0, 0, 0, 0));
        tick();
        Start = '0;
        Tx_ValidFrame = 1'b1;
        repeat (4) tick();
        Tx_ValidFrame = 1'b0;
        Abort = 4'b0001;
        Req = '0;
        exp_ev("done_vs_abort", c + 7, mk(4'b0000, 1, 0, 0, 4'b0001, 0, 0));
        exp_ev("gap_end", c + 16, mk(0, 0, 0, 0, 0, 0, 0));
        tick();
        Abort = '0;
        repeat (10) tick();

        // Client 0 granted; Start/Abort from client 3 do nothing; Req drop releases.
        c = cyc;
        Req = 4'b0001;
        exp_ev("grant", c + 1, mk(4'b0001, 1, 0, 0, 0, 0, 0));
        tick();
        Start = 4'b1000;
        Abort = 4'b1000;
        tick();
        Start = '0;
        Abort = '0;
        repeat (2) tick();
        Req = '0;
        exp_ev("req_release", c + 5, mk(0, 0, 0, 0, 0, 0, 0));
        repeat (3) tick();

        // Reset while sending, then pointer must restart at 0.
        c = cyc;
        Req = 4'b0010;
        exp_ev("grant", c + 1, mk(4'b0010, 1, 0, 0, 0, 0, 0));
        tick();
        Start = 4'b0010;
        exp_ev("tx_enable", c + 2, mk(4'b0010, 1, 1, 0, 0, 0, 0));
        tick();
        Start = '0;
        Tx_ValidFrame = 1'b1;
        repeat (3) tick();
        Rst = 1'b0;
        exp_ev("reset_drop", c + 6, mk(0, 0, 0, 0, 0, 0, 0));
        tick();
        Rst = 1'b1;
        Tx_ValidFrame = 1'b0;
        Req = 4'b0011;
        exp_ev("grant_after_reset", c + 7, mk(4'b0001, 1, 0, 0, 0, 0, 0));
        tick();
        Req = '0;
        exp_ev("req_release", c + 8, mk(0, 0, 0, 0, 0, 0, 0));
        repeat (6) tick();

        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained: %0d events outstanding, required 0", q.size());
        end
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hdlc_tx_scheduler.md
Name: hdlc_tx_scheduler

Overview:
Shares the single HDLC transmitter between N_REQ client requesters using round-robin arbitration.
Sequences each frame: grant, start (Tx_Enable), monitor Tx_ValidFrame, optional abort (Tx_AbortFrame), then an idle gap so the end or abort flag fully leaves Tx before the next frame.
Sits between client channels and the HDLC Tx datapath; the granted client owns the shared Tx buffer write port.

Parameters:
N_REQ, 4, number of requesters (2..8)
GAP_CYCLES, 9, idle cycles after Tx_ValidFrame falls before the next grant (covers end/abort flag)
START_TIMEOUT, 64, max cycles from Tx_Enable to Tx_ValidFrame rising

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  synchronous, active-low reset
Req  in  N_REQ  per-client request level; held until Done/Aborted/Timeout of that client
Start  in  N_REQ  per-client pulse: buffer loaded, begin frame (honoured only from granted client)
Abort  in  N_REQ  per-client pulse: abort current frame (honoured only from granted client)
Grant  out  N_REQ  one-hot ownership of Tx path
Done  out  N_REQ  one-cycle pulse: frame completed normally
Aborted  out  N_REQ  one-cycle pulse: frame aborted (Tx_AbortedTrans seen)
Timeout  out  N_REQ  one-cycle pulse: Tx_ValidFrame never rose
Busy  out  1  high in any state except IDLE
Tx_Enable  out  1  one-cycle pulse to transmitter: start frame
Tx_AbortFrame  out  1  one-cycle pulse to transmitter: abort frame
Tx_ValidFrame  in  1  transmitter frame-in-progress
Tx_AbortedTrans  in  1  transmitter reports aborted transmission

Behaviour:
- Reset (Rst=0 at posedge): all outputs 0, state IDLE, counter 0, RR pointer 0. Reset mid-frame drops Grant immediately; no Done/Aborted pulse is issued.
- All outputs are registered. Pulse outputs last exactly one cycle.
- IDLE: if Req!=0, pick the first set bit searching from ptr upward with wrap. The next cycle Grant is one-hot for that client and the state is GRANTED; ptr = winner+1 mod N_REQ.
- GRANTED:
  - Start[g]=1 -> Tx_Enable=1 next cycle, counter cleared, WAIT_VALID.
  - Else Req[g]=0 -> Grant cleared, IDLE (no gap, no status pulse).
  - Abort[g] in GRANTED is ignored.
- WAIT_VALID:
  - Tx_ValidFrame=1 -> SENDING.
  - Abort[g] -> Tx_AbortFrame pulse, ABORTING.
  - Counter reaches START_TIMEOUT-1 -> Timeout[g] pulse, Grant cleared, GAP.
  - If Tx_ValidFrame and Abort[g] are seen in the same cycle, abort wins.
- SENDING:
  - Tx_ValidFrame=0 -> Done[g] pulse, Grant cleared, GAP.
  - Abort[g] -> Tx_AbortFrame pulse, ABORTING.
  - If Abort and the Tx_ValidFrame fall occur in the same cycle, completion wins: Done, no Tx_AbortFrame.
- ABORTING: wait for Tx_ValidFrame=0; track whether Tx_AbortedTrans was high at any cycle since entry.
  - On exit, emit Aborted[g] if it was seen, else Done[g]. Grant cleared, GAP.
  - Tx_AbortFrame is issued at most once per frame.
- GAP: counter counts GAP_CYCLES cycles, Grant=0, Busy=1, then IDLE. Requests are re-arbitrated only in IDLE.
- Req deassertion after GRANTED is ignored until the frame resolves.
- Start/Abort from non-granted clients are always ignored.
- Counter width is $clog2(max(GAP_CYCLES, START_TIMEOUT)+1). Counter saturates and never wraps.
- Invariants: Grant one-hot or zero; Tx_Enable and Tx_AbortFrame never high in the same cycle; exactly one of Done/Aborted/Timeout per Tx_Enable.

Decomposition:
- Package hdlc_ctrl_pkg holds:
  - state enum (IDLE, GRANTED, WAIT_VALID, SENDING, ABORTING, GAP);
  - GAP and timeout default constants;
  - the counter-width function.
- One sub-module, hdlc_rr_arbiter: a combinational round-robin pick from Req and ptr, producing a one-hot winner plus an index.

Test Plan:
1. Req=4'b0010, Start[1], then Tx_ValidFrame high 20 cycles -> Grant=0010 next cycle; Tx_Enable one cycle after Start; Done[1] one cycle after the Tx_ValidFrame fall; Busy drops 9 cycles later.
2. Req=4'b1111 held through four frames -> grants in order 0001, 0010, 0100, 1000; each next grant comes ≥9 cycles after the previous Done.
3. Client 2 Abort mid-SENDING with Tx_AbortedTrans pulsed -> single Tx_AbortFrame pulse; Aborted[2] when Tx_ValidFrame falls; no Done[2].
4. Start issued, Tx_ValidFrame held low -> Timeout[g] exactly 64 cycles after Tx_Enable; Grant cleared; GAP entered.
5. Abort and the Tx_ValidFrame fall in the same cycle -> Done only, Tx_AbortFrame stays 0. In a separate run, Start[3] while client 0 is granted -> no Tx_Enable.
6. Rst=0 asserted during SENDING -> next cycle all outputs 0 and state IDLE; after release, Req=0001 is granted with ptr starting at 0.
